// File: rtl/cu_fsm_intr.sv
// RAT MCU control unit: fetch/execute FSM, full-ISA decode and a
// vectored, prioritised interrupt controller with synchronised inputs.
module cu_fsm_intr #(
    parameter int NUM_IRQ  = 4,
    parameter int IRQ_SYNC = 2,
    parameter int IRQ_EDGE = 1,
    parameter int VEC_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               c,
    input  logic               z,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [4:0]         opcode_hi5,
    input  logic [1:0]         opcode_lo2,
    output logic               rf_wr,
    output logic [1:0]         rf_wr_sel,
    output logic               sp_ld,
    output logic               sp_incr,
    output logic               sp_decr,
    output logic               scr_we,
    output logic               scr_data_sel,
    output logic [1:0]         scr_addr_sel,
    output logic               pc_ld,
    output logic               pc_inc,
    output logic [1:0]         pc_mux_sel,
    output logic [VEC_W-1:0]   int_vec,
    output logic               alu_opy_sel,
    output logic [3:0]         alu_sel,
    output logic               flg_c_set,
    output logic               flg_c_clr,
    output logic               flg_c_ld,
    output logic               flg_z_ld,
    output logic               flg_ld_sel,
    output logic               flg_shad_ld,
    output logic               io_strb,
    output logic [NUM_IRQ-1:0] int_ack,
    output logic               i_flag,
    output logic               rst
);

    typedef enum logic [1:0] {
        ST_INIT, ST_FETCH, ST_EXEC, ST_INTR
    } state_t;

    localparam logic [6:0] OP_SEI   = 7'b0110100;
    localparam logic [6:0] OP_CLI   = 7'b0110101;
    localparam logic [6:0] OP_RETID = 7'b0110110;
    localparam logic [6:0] OP_RETIE = 7'b0110111;

    state_t             state;
    logic [6:0]         op;
    logic [NUM_IRQ-1:0] irq_s;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] ack_oh;
    logic [NUM_IRQ-1:0] clr;
    logic [VEC_W-1:0]   k_q;
    logic               take_intr;

    assign op        = {opcode_hi5, opcode_lo2};
    assign take_intr = i_flag && (|pend);
    assign ack_oh    = NUM_IRQ'(1) << k_q;
    assign clr       = (state == ST_INTR) ? ack_oh : '0;

    function automatic logic [VEC_W-1:0] lowest(input logic [NUM_IRQ-1:0] p);
        lowest = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (p[i]) lowest = VEC_W'(i);
    endfunction

    generate
        if (IRQ_SYNC == 0) begin : g_nosync
            assign irq_s = irq;
        end else begin : g_sync
            logic [NUM_IRQ-1:0] sff [IRQ_SYNC];
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < IRQ_SYNC; i++) sff[i] <= '0;
                end else begin
                    sff[0] <= irq;
                    for (int i = 1; i < IRQ_SYNC; i++) sff[i] <= sff[i-1];
                end
            end
            assign irq_s = sff[IRQ_SYNC-1];
        end

        if (IRQ_EDGE != 0) begin : g_edge
            logic [NUM_IRQ-1:0] irq_q;
            logic [NUM_IRQ-1:0] pend_q;
            // a fresh rising edge overrides the clear of the serviced channel
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    irq_q  <= '0;
                    pend_q <= '0;
                end else begin
                    irq_q  <= irq_s;
                    pend_q <= (pend_q & ~clr) | (irq_s & ~irq_q);
                end
            end
            assign pend = pend_q;
        end else begin : g_level
            assign pend = irq_s;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_INIT;
            i_flag <= 1'b0;
            k_q    <= '0;
        end else begin
            unique case (state)
                ST_INIT:  state <= ST_FETCH;
                ST_FETCH: state <= ST_EXEC;
                ST_EXEC: begin
                    if (take_intr) begin
                        state <= ST_INTR;
                        k_q   <= lowest(pend);
                    end else begin
                        state <= ST_FETCH;
                    end
                    if (op == OP_SEI || op == OP_RETIE)
                        i_flag <= 1'b1;
                    else if (op == OP_CLI || op == OP_RETID)
                        i_flag <= 1'b0;
                end
                ST_INTR: begin
                    state  <= ST_FETCH;
                    i_flag <= 1'b0;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    always_comb begin
        rf_wr        = 1'b0;
        rf_wr_sel    = 2'd0;
        sp_ld        = 1'b0;
        sp_incr      = 1'b0;
        sp_decr      = 1'b0;
        scr_we       = 1'b0;
        scr_data_sel = 1'b0;
        scr_addr_sel = 2'd0;
        pc_ld        = 1'b0;
        pc_inc       = 1'b0;
        pc_mux_sel   = 2'd0;
        int_vec      = '0;
        alu_opy_sel  = 1'b0;
        alu_sel      = 4'd0;
        flg_c_set    = 1'b0;
        flg_c_clr    = 1'b0;
        flg_c_ld     = 1'b0;
        flg_z_ld     = 1'b0;
        flg_ld_sel   = 1'b0;
        flg_shad_ld  = 1'b0;
        io_strb      = 1'b0;
        int_ack      = '0;
        rst          = 1'b0;
        unique case (state)
            ST_INIT:  rst = 1'b1;
            ST_FETCH: pc_inc = 1'b1;
            ST_INTR: begin
                int_ack      = ack_oh;
                int_vec      = k_q;
                scr_we       = 1'b1;
                scr_data_sel = 1'b1;
                scr_addr_sel = 2'd3;
                sp_decr      = 1'b1;
                pc_ld        = 1'b1;
                pc_mux_sel   = 2'd2;
                flg_shad_ld  = 1'b1;
            end
            ST_EXEC: begin
                // op[6] distinguishes immediate forms from reg/reg forms
                unique casez (op)
                    7'b0000000, 7'b10000??: begin
                        alu_sel = 4'd5; alu_opy_sel = op[6];
                        rf_wr = 1'b1; flg_c_clr = 1'b1; flg_z_ld = 1'b1;
                    end
                    7'b0000001, 7'b10001??: begin
                        alu_sel = 4'd6; alu_opy_sel = op[6];
                        rf_wr = 1'b1; flg_c_clr = 1'b1; flg_z_ld = 1'b1;
                    end
                    7'b0000010, 7'b10010??: begin
                        alu_sel = 4'd7; alu_opy_sel = op[6];
                        rf_wr = 1'b1; flg_c_clr = 1'b1; flg_z_ld = 1'b1;
                    end
                    7'b0000011, 7'b10011??: begin
                        alu_sel = 4'd8; alu_opy_sel = op[6];
                        flg_c_clr = 1'b1; flg_z_ld = 1'b1;
                    end
                    7'b0000100, 7'b10100??: begin
                        alu_sel = 4'd0; alu_opy_sel = op[6];
                        rf_wr = 1'b1; flg_c_ld = 1'b1; flg_z_ld = 1'b1;
                    end
                    7'b0000101, 7'b10101??: begin
                        alu_sel = 4'd1; alu_opy_sel = op[6];
                        rf_wr = 1'b1; flg_c_ld = 1'b1; flg_z_ld = 1'b1;
                    end
                    7'b0000110, 7'b10110??: begin
                        alu_sel = 4'd2; alu_opy_sel = op[6];
                        rf_wr = 1'b1; flg_c_ld = 1'b1; flg_z_ld = 1'b1;
                    end
                    7'b0000111, 7'b10111??: begin
                        alu_sel = 4'd3; alu_opy_sel = op[6];
                        rf_wr = 1'b1; flg_c_ld = 1'b1; flg_z_ld = 1'b1;
                    end
                    7'b0001000, 7'b11000??: begin
                        alu_sel = 4'd4; alu_opy_sel = op[6];
                        flg_c_ld = 1'b1; flg_z_ld = 1'b1;
                    end
                    7'b0001001, 7'b11011??: begin
                        alu_sel = 4'd14; alu_opy_sel = op[6];
                        rf_wr = 1'b1;
                    end
                    7'b0001010, 7'b11100??: begin
                        rf_wr = 1'b1; rf_wr_sel = 2'd1;
                        scr_addr_sel = {1'b0, op[6]};
                    end
                    7'b0001011, 7'b11101??: begin
                        scr_we = 1'b1;
                        scr_addr_sel = {1'b0, op[6]};
                    end
                    7'b11001??: begin
                        rf_wr = 1'b1; rf_wr_sel = 2'd3;
                    end
                    7'b11010??: io_strb = 1'b1;
                    7'b0010000: pc_ld = 1'b1;
                    7'b0010001: begin
                        pc_ld = 1'b1; scr_we = 1'b1; scr_data_sel = 1'b1;
                        scr_addr_sel = 2'd3; sp_decr = 1'b1;
                    end
                    7'b0010010: pc_ld = z;
                    7'b0010011: pc_ld = ~z;
                    7'b0010100: pc_ld = c;
                    7'b0010101: pc_ld = ~c;
                    7'b0100000, 7'b0100001, 7'b0100010,
                    7'b0100011, 7'b0100100: begin
                        alu_sel = 4'd9 + {1'b0, op[2:0]};
                        rf_wr = 1'b1; flg_c_ld = 1'b1; flg_z_ld = 1'b1;
                    end
                    7'b0100101: begin
                        scr_we = 1'b1; scr_addr_sel = 2'd3; sp_decr = 1'b1;
                    end
                    7'b0100110: begin
                        rf_wr = 1'b1; rf_wr_sel = 2'd1;
                        scr_addr_sel = 2'd2; sp_incr = 1'b1;
                    end
                    7'b0101000: sp_ld = 1'b1;
                    7'b0101001: begin
                        rf_wr = 1'b1; rf_wr_sel = 2'd2;
                    end
                    7'b0110000: flg_c_clr = 1'b1;
                    7'b0110001: flg_c_set = 1'b1;
                    7'b0110010, 7'b011011?: begin
                        pc_ld = 1'b1; pc_mux_sel = 2'd1;
                        scr_addr_sel = 2'd2; sp_incr = 1'b1;
                        flg_ld_sel = op[2];
                        flg_c_ld   = op[2];
                        flg_z_ld   = op[2];
                    end
                    default: ;
                endcase
            end
            default: rst = 1'b1;
        endcase
    end

endmodule
